keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Input end of the keypad-to-display path: scans a 4x4 matrix keypad (PmodKYPD), synchronises and
//   debounces the row returns, and produces one hex key code per physical press.
//   key_code/key_valid feed the game input logic, which writes digits into the number shown by the
//   seven-segment display controller.
// PARAMETERS
//   SCAN_CYCLES     100000  clocks each column is driven low (1 ms at 100 MHz); must be >= 4
//   DEBOUNCE_SCANS  4       consecutive identical full sweeps needed to accept a press or a release; >= 1
// PORTS
//   clock      in   1   system clock, all logic on rising edge
//   reset      in   1   asynchronous, active-high; clears all state immediately
//   row        in   4   keypad row returns, active-low, asynchronous to clock
//   col        out  4   keypad column drives, active-low, exactly one bit low at all times
//   key_code   out  4   hex value of the accepted key; stable while key_held = 1
//   key_valid  out  1   one-cycle pulse when a debounced press is accepted
//   key_held   out  1   high from acceptance until the debounced release
// BEHAVIOUR
//   Reset values: col=4'b1110, key_code=4'h0, key_valid=0, key_held=0, FSM=IDLE, all counters 0, sync flops 1.
//   Scanning:
//   - Column index 0..3 advances every SCAN_CYCLES clocks and wraps 3->0; col = ~(4'b0001 << index).
//   - One sweep = 4*SCAN_CYCLES clocks.
//   - row passes through a 2-flop synchroniser.
//   - The synchronised row is sampled on the last cycle of each column window (cycle SCAN_CYCLES-1).
//   Sweep result:
//   - hit=1 if any sampled row bit was 0 during the sweep.
//   - code = first hit in order column 0..3, then row 0..3 within a column. Later hits are ignored.
//   - The result is evaluated once, on the last cycle of the column-3 window.
//   Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
//   FSM (advances only at sweep evaluation):
//   - IDLE: hit -> PEND with cand=code, cnt=1. With DEBOUNCE_SCANS=1, go straight to HELD (accept).
//     No hit -> stay in IDLE.
//   - PEND:
//     - hit with code==cand: cnt+1; when cnt reaches DEBOUNCE_SCANS -> HELD (accept).
//     - hit with code!=cand: cand=code, cnt=1.
//     - no hit: back to IDLE, cnt=0.
//   - HELD:
//     - A sweep whose result is not exactly (hit, key_code) increments rel_cnt.
//     - A matching sweep clears rel_cnt.
//     - When rel_cnt reaches DEBOUNCE_SCANS -> IDLE, key_held=0, no pulse.
//     - A different key pressed while held is not reported until after a full release.
//   Accept (registered, appears the cycle after evaluation):
//   - key_code=cand, key_held=1, key_valid=1 for exactly one cycle.
//   - No auto-repeat: a held key yields one pulse.
//   Latency: from a stable press to key_valid is at most (DEBOUNCE_SCANS+1) sweeps + 3 clocks.
//   Counters: sized $clog2 of their terminal value; they never overflow (saturate/reset at terminal).
//   Reset mid-operation:
//   - Asserting reset at any time forces the reset values immediately, including aborting a key_valid pulse.
//   - After reset deasserts, a full debounce is required again. A key already down is then reported once.
// TESTING  (SCAN_CYCLES=8, DEBOUNCE_SCANS=3, sweep = 32 clocks)
//   1. Reset, rows all 1 -> col 1110,1101,1011,0111 each for 8 clocks, then repeats;
//      key_valid/key_held stay 0 for 10 sweeps.
//   2. Model '5' (row1 low while col1 low) for 6 sweeps -> exactly one key_valid with key_code=4'h5
//      after the 3rd full sweep; key_held=1.
//   3. 'A' for 2 sweeps, 1 sweep released, 'A' for 2 sweeps, then released -> no key_valid ever.
//   4. Hold '9' until accepted; drop for 1 sweep; hold 2 sweeps; release -> no second pulse;
//      key_held falls 3 sweeps after the final release; key_code stays 9.
//   5. '1' and '0' pressed together (col0, rows 0 and 3) -> single pulse with key_code=4'h1.
//   6. Press 'C'; assert reset for 5 clocks after the 2nd sweep -> outputs clear asynchronously;
//      keep 'C' down -> pulse with key_code=4'hC only after 3 full post-reset sweeps.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, synchronises the
// row returns, reduces each full sweep to (hit, code) and debounces presses and
// releases over whole sweeps. Emits one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CYC_W = $clog2(SCAN_CYCLES);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_T     = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_HELD} state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [CYC_W-1:0] r_cyc;
  logic [1:0]       r_col_idx;
  logic             r_sweep_hit;
  logic [3:0]       r_sweep_code;
  state_t           r_state;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_sample;
  logic             w_eval;
  logic             w_col_hit;
  logic [1:0]       w_row_idx;
  logic [3:0]       w_col_code;
  logic             w_hit;
  logic [3:0]       w_code;
  state_t           w_state_nx;
  logic [3:0]       w_cand_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_rel_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_rel_inc;
  logic             w_accept;
  logic             w_release;

  // Key legend indexed by row (upper bits) and column (lower bits).
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

  assign w_sample   = (r_cyc == CYC_LAST);
  assign w_eval     = w_sample && (r_col_idx == 2'd3);
  assign w_col_hit  = ~&r_sync2;
  assign w_col_code = key_map(w_row_idx, r_col_idx);
  assign w_hit      = r_sweep_hit | w_col_hit;
  assign w_code     = r_sweep_hit ? r_sweep_code : w_col_code;
  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_rel_inc  = r_rel_cnt + CNT_ONE;

  // Lowest-numbered active row wins within a column.
  always_comb begin
    if (!r_sync2[0])      w_row_idx = 2'd0;
    else if (!r_sync2[1]) w_row_idx = 2'd1;
    else if (!r_sync2[2]) w_row_idx = 2'd2;
    else                  w_row_idx = 2'd3;
  end

  // Two-flop synchroniser for the asynchronous row returns (idle high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= row;
      r_sync2 <= r_sync1;
    end
  end

  // Column window timer and column index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cyc     <= '0;
      r_col_idx <= '0;
    end else if (w_sample) begin
      r_cyc     <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_cyc     <= r_cyc + CYC_W'(1);
    end
  end

  // Sweep accumulator: keeps the first hit; cleared once the sweep is evaluated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sweep_hit  <= 1'b0;
      r_sweep_code <= '0;
    end else if (w_eval) begin
      r_sweep_hit  <= 1'b0;
      r_sweep_code <= '0;
    end else if (w_sample && !r_sweep_hit && w_col_hit) begin
      r_sweep_hit  <= 1'b1;
      r_sweep_code <= w_col_code;
    end
  end

  // Debounce FSM state and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_rel_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cand    <= w_cand_nx;
      r_cnt     <= w_cnt_nx;
      r_rel_cnt <= w_rel_nx;
    end
  end

  // Debounce FSM next state; only moves at sweep evaluation.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_rel_nx   = r_rel_cnt;
    w_accept   = 1'b0;
    w_release  = 1'b0;
    if (w_eval) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            w_cand_nx = w_code;
            if (DB_T == CNT_ONE) begin
              w_state_nx = S_HELD;
              w_accept   = 1'b1;
              w_cnt_nx   = '0;
            end else begin
              w_state_nx = S_PEND;
              w_cnt_nx   = CNT_ONE;
            end
          end
        end
        S_PEND: begin
          if (!w_hit) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else if (w_code == r_cand) begin
            if (w_cnt_inc == DB_T) begin
              w_state_nx = S_HELD;
              w_accept   = 1'b1;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx   = w_cnt_inc;
            end
          end else begin
            w_cand_nx = w_code;
            w_cnt_nx  = CNT_ONE;
          end
        end
        S_HELD: begin
          if (w_hit && (w_code == r_key_code)) begin
            w_rel_nx = '0;
          end else if (w_rel_inc == DB_T) begin
            w_state_nx = S_IDLE;
            w_rel_nx   = '0;
            w_release  = 1'b1;
          end else begin
            w_rel_nx   = w_rel_inc;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_rel_nx   = '0;
        end
      endcase
    end
  end

  // Registered key outputs: one-cycle pulse on accept, held until release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= w_cand_nx;
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_CYCLES=8, DEBOUNCE_SCANS=3 (32-clock sweep).
// A matrix model drives row from col and the set of pressed keys; expected key
// codes are queued at press time and popped on each key_valid pulse.
module tb_keypad_scanner;

  localparam int unsigned SC = 8;
  localparam int unsigned DB = 3;
  localparam int unsigned SW = 4 * SC;

  localparam logic [3:0] KMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic       clock;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic [3:0]  sb [$];
  int          n_checks;
  int          n_err;
  int          pulses;
  int          exp_pulses;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_idx(input logic [3:0] k);
    for (int i = 0; i < 16; i++)
      if (KMAP[i] == k) return i;
    return 0;
  endfunction

  task automatic press(input logic [3:0] k);
    pressed[key_idx(k)] = 1'b1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Scoreboard consumer: every key_valid pulse is counted and matched in order.
  always @(negedge clock) begin
    if (!reset && key_valid) begin
      pulses++;
      if (sb.size() > 0) begin
        logic [3:0] e;
        e = sb.pop_front();
        chk("pulse_code", key_code, e);
        chk("pulse_held", key_held, 1);
      end
    end
  end

  initial begin
    logic [3:0] ecol;
    n_checks = 0; n_err = 0; pulses = 0; exp_pulses = 0;
    pressed = '0;
    reset = 1'b1;
    wait_clk(3);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    reset = 1'b0;

    // 1: idle scan, column sequence and no activity for 10 sweeps
    for (int n = 0; n < 10 * SW; n++) begin
      if ((n % SC == 0) || (n % SC == SC - 1)) begin
        ecol = 4'b1111;
        ecol[(n / SC) % 4] = 1'b0;
        chk("col_seq", col, ecol);
      end
      if (n % SW == 0) chk("idle_held", key_held, 0);
      @(negedge clock);
    end
    chk("idle_pulses", pulses, exp_pulses);

    // 2: '5' held 6 sweeps, accepted exactly after the 3rd sweep
    press(4'h5); sb.push_back(4'h5); exp_pulses++;
    wait_clk(3 * SW - 1);
    chk("k5_early", key_valid, 0);
    wait_clk(1);
    chk("k5_valid", key_valid, 1);
    wait_clk(1);
    chk("k5_one_cycle", key_valid, 0);
    wait_clk(3 * SW - 1);
    chk("k5_held", key_held, 1);
    chk("k5_code", key_code, 4'h5);
    pressed = '0;
    wait_clk(4 * SW);
    chk("k5_released", key_held, 0);
    chk("k5_pulses", pulses, exp_pulses);

    // 3: bouncing 'A' never reaches the debounce count
    press(4'hA); wait_clk(2 * SW);
    pressed = '0; wait_clk(SW);
    press(4'hA); wait_clk(2 * SW);
    pressed = '0; wait_clk(4 * SW);
    chk("kA_held", key_held, 0);
    chk("kA_pulses", pulses, exp_pulses);

    // 4: '9' accepted, short drop does not release, release after 3 sweeps
    press(4'h9); sb.push_back(4'h9); exp_pulses++;
    wait_clk(3 * SW);
    chk("k9_held", key_held, 1);
    pressed = '0; wait_clk(SW);
    press(4'h9); wait_clk(2 * SW);
    chk("k9_still_held", key_held, 1);
    pressed = '0;
    wait_clk(3 * SW - 1);
    chk("k9_rel_early", key_held, 1);
    wait_clk(1);
    chk("k9_rel", key_held, 0);
    chk("k9_code_kept", key_code, 4'h9);
    wait_clk(SW - 1);
    chk("k9_pulses", pulses, exp_pulses);

    // 5: '1' and '0' together in column 0 -> row 0 wins
    wait_clk(1);
    press(4'h1); press(4'h0); sb.push_back(4'h1); exp_pulses++;
    wait_clk(4 * SW);
    chk("k10_held", key_held, 1);
    chk("k10_code", key_code, 4'h1);
    pressed = '0;
    wait_clk(4 * SW);
    chk("k10_released", key_held, 0);
    chk("k10_pulses", pulses, exp_pulses);

    // 6: 'C' interrupted by reset mid-sweep, then reported after a fresh debounce
    press(4'hC);
    wait_clk(2 * SW + 10);
    reset = 1'b1;
    #1;
    chk("kC_rst_col", col, 4'b1110);
    chk("kC_rst_code", key_code, 4'h0);
    chk("kC_rst_held", key_held, 0);
    wait_clk(5);
    reset = 1'b0;
    sb.push_back(4'hC); exp_pulses++;
    wait_clk(3 * SW - 1);
    chk("kC_early", key_valid, 0);
    wait_clk(1);
    chk("kC_valid", key_valid, 1);
    chk("kC_code", key_code, 4'hC);
    // reset during the pulse aborts it immediately
    #2;
    reset = 1'b1;
    #1;
    chk("kC_abort_valid", key_valid, 0);
    chk("kC_abort_held", key_held, 0);
    chk("kC_abort_code", key_code, 4'h0);
    wait_clk(2);
    reset = 1'b0;
    sb.push_back(4'hC); exp_pulses++;
    wait_clk(3 * SW - 1);
    chk("kC2_early", key_valid, 0);
    wait_clk(1);
    chk("kC2_valid", key_valid, 1);
    pressed = '0;
    wait_clk(4 * SW);
    chk("kC_released", key_held, 0);
    chk("final_pulses", pulses, exp_pulses);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
